// File: rtl/imem_pkg.sv
// Shared types and constants for the IMEM boot loader.
// IMEM_LOADER_CHECKSUM_EN adds the CHECK/ERROR states.
package imem_pkg;

  localparam int          IMEM_WORDS = 32;
  localparam int          IMEM_AW    = 5;
  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } loader_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd4
  } loader_state_t;
`endif

  // States in which the loader owns the IMEM address port.
  function automatic logic is_loading(loader_state_t s);
`ifdef IMEM_LOADER_CHECKSUM_EN
    return (s == ST_LOAD) || (s == ST_WRITE) || (s == ST_CHECK);
`else
    return (s == ST_LOAD) || (s == ST_WRITE);
`endif
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and IMEM write/address port of the boot loader.
// master = loader side, slave = byte source / IMEM side.
interface imem_boot_loader_if #(
  parameter int AW = imem_pkg::IMEM_AW
);
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic [AW-1:0] imem_addr;
  logic          imem_we;
  logic [31:0]   imem_wdata;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, imem_addr, imem_we, imem_wdata
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, imem_addr, imem_we, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_assembler.sv
// Little-endian byte-to-word assembler: byte index counter, byte insert
// and a word-complete strobe on acceptance of the 4th byte.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  logic [1:0]  idx_q;
  logic [31:0] word_q;

  assign done_o = accept_i && (idx_q == 2'd3);
  assign word_o = word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (clr_i) begin
      idx_q  <= '0;
    end else if (accept_i) begin
      // idx wraps 3 -> 0 so the next word starts at byte lane 0
      idx_q              <= idx_q + 2'd1;
      word_q[idx_q*8 +: 8] <= byte_i;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot-time IMEM filler: assembles a byte stream into words, writes IMEM,
// arbitrates the IMEM address with the core PC and holds the core until done.
// Optional checksum byte check under IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import imem_pkg::*;
#(
  parameter int WORDS = IMEM_WORDS,
  parameter int AW    = IMEM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        pc,
  imem_boot_loader_if.master bus,
  output logic               cpu_hold,
  output logic               load_done,
  output logic [AW:0]        word_count,
  output logic               err
);

  if (AW != $clog2(WORDS)) begin : g_bad_aw
    $error("imem_boot_loader: AW must equal clog2(WORDS)");
  end

  loader_state_t state_q, state_d;
  logic [AW-1:0] widx_q;
  logic [AW:0]   wcnt_q;
  logic          byte_ready_q, imem_we_q, cpu_hold_q, load_done_q;
  logic          accept, asm_accept, word_done, last_word, begin_load;
  logic [31:0]   asm_word;
  logic          unused_pc;

  assign accept     = bus.byte_valid && byte_ready_q;
  assign asm_accept = accept && (state_q == ST_LOAD);
  assign last_word  = (widx_q == AW'(WORDS - 1));
  assign unused_pc  = ^{pc[31:AW+2], pc[1:0]};

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  byte_word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (begin_load),
    .accept_i (asm_accept),
    .byte_i   (bus.byte_data),
    .word_o   (asm_word),
    .done_o   (word_done)
  );

  always_comb begin
    state_d    = state_q;
    begin_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_LOAD;
          begin_load = 1'b1;
        end
      end
      ST_LOAD: if (word_done) state_d = ST_WRITE;
      ST_WRITE: begin
        if (!last_word) state_d = ST_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
        else            state_d = ST_CHECK;
`else
        else            state_d = ST_DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: if (accept) state_d = (bus.byte_data == sum_q) ? ST_DONE : ST_ERROR;
      ST_ERROR: begin
        if (start) begin
          state_d    = ST_LOAD;
          begin_load = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      widx_q       <= '0;
      wcnt_q       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      byte_ready_q <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
      err_q        <= (state_d == ST_ERROR);
      if (begin_load)      sum_q <= '0;
      else if (asm_accept) sum_q <= sum_q + bus.byte_data;
`else
      byte_ready_q <= (state_d == ST_LOAD);
`endif
      imem_we_q    <= (state_d == ST_WRITE);
      cpu_hold_q   <= (state_d != ST_DONE);
      load_done_q  <= (state_d == ST_DONE);
      if (begin_load) begin
        widx_q <= '0;
        wcnt_q <= '0;
      end else if (state_q == ST_WRITE) begin
        // index parks on the last word; count saturates at WORDS
        if (!last_word)                      widx_q <= widx_q + 1'b1;
        if (wcnt_q != (AW+1)'(WORDS))        wcnt_q <= wcnt_q + 1'b1;
      end
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_wdata = asm_word;
  assign bus.imem_addr  = is_loading(state_q) ? widx_q : pc[AW+1:2];
  assign cpu_hold       = cpu_hold_q;
  assign load_done      = load_done_q;
  assign word_count     = wcnt_q;

endmodule
